// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl
//   Moves bursts of words between two streaming handshakes and a
//   single-port synchronous SRAM. A write burst forwards each accepted write
//   beat straight to the SRAM. A read burst issues reads into a 2-entry output
//   FIFO and stops issuing while that FIFO, together with any read still in
//   flight, is full.
//
// Ports
//   CLK, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready             burst command handshake
//   cmd_wr, cmd_addr, cmd_len       direction, start word, beats minus one
//   wdata_valid/wdata_ready, wdata  write-beat stream
//   rdata_valid/rdata_ready         read-beat stream
//   rdata, rdata_last               read beat and end-of-burst flag
//   busy                            controller is not idle
//   CEN, WEN, A, D, Q               SRAM port (enables are active-low)
module sram_burst_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              busy,
    output logic              CEN,
    output logic              WEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] Q
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_beats;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_last;
    logic              r_head;
    logic [1:0]        r_count;
    logic              r_inflight;
    logic              r_infl_last;

    logic              w_cmd_hs;
    logic              w_wr_hs;
    logic              w_pop;
    logic              w_issue;
    logic [2:0]        w_occ;
    logic              w_tail;

    // Outputs that would start a transfer are gated off during reset so a
    // reset cycle can never accept a command or touch the SRAM.
    assign cmd_ready   = !reset && (r_state == S_IDLE);
    assign wdata_ready = !reset && (r_state == S_WRITE);
    assign rdata_valid = !reset && (r_count != 2'd0);
    assign rdata       = r_fifo_data[r_head];
    assign rdata_last  = rdata_valid && r_fifo_last[r_head];
    assign busy        = (r_state != S_IDLE);

    assign w_cmd_hs = cmd_valid && cmd_ready;
    assign w_wr_hs  = wdata_valid && wdata_ready;
    assign w_pop    = rdata_valid && rdata_ready;

    // Buffered beats plus the read in flight must stay within the two FIFO
    // slots; a pop in this cycle frees one slot in time for the next push.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_issue = !reset && (r_state == S_READ) &&
                     (w_occ < (3'd2 + {2'b00, w_pop}));

    // Occupancy never exceeds 2, and a push only happens while count < 2,
    // so the free slot is the head when empty and the other slot otherwise.
    assign w_tail = r_head ^ r_count[0];

    always_comb begin
        CEN = 1'b1;
        WEN = 1'b1;
        A   = '0;
        D   = '0;
        if (w_wr_hs) begin
            CEN = 1'b0;
            WEN = 1'b0;
            A   = r_addr;
            D   = wdata;
        end else if (w_issue) begin
            CEN = 1'b0;
            A   = r_addr;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_beats     <= '0;
            r_head      <= 1'b0;
            r_count     <= 2'd0;
            r_inflight  <= 1'b0;
            r_infl_last <= 1'b0;
        end else begin
            // Q is valid the cycle after issue, so the inflight flag doubles
            // as the FIFO push strobe.
            r_inflight  <= w_issue;
            r_infl_last <= w_issue && (r_beats == '0);
            r_count     <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
            if (w_pop) r_head <= ~r_head;

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        r_addr  <= cmd_addr;
                        r_beats <= cmd_len;
                        r_state <= cmd_wr ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (w_wr_hs) begin
                        r_addr <= r_addr + 1'b1;
                        if (r_beats == '0) r_state <= S_IDLE;
                        else               r_beats <= r_beats - 1'b1;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_addr <= r_addr + 1'b1;
                        if (r_beats == '0) r_state <= S_DRAIN;
                        else               r_beats <= r_beats - 1'b1;
                    end
                end
                default: begin
                    if ((r_count == 2'd0) && !r_inflight) r_state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO payload carries no reset; only the occupancy count gives it meaning.
    always_ff @(posedge CLK) begin
        if (!reset && r_inflight) begin
            r_fifo_data[w_tail] <= Q;
            r_fifo_last[w_tail] <= r_infl_last;
        end
    end

endmodule

// File: doc/sram_burst_ctrl.md
SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 Parameter: ADDR_W, 11, SRAM word-address width; address space 2^ADDR_W words.
REQ-002 Parameter: DATA_W, 32, SRAM word width.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  burst command offered.
REQ-006 cmd_ready  output  1  controller accepts command.
REQ-007 cmd_wr  input  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  input  ADDR_W  burst start word address.
REQ-009 cmd_len  input  ADDR_W  beats minus one (0 = 1 beat, 2047 = 2048 beats).
REQ-010 wdata_valid / wdata_ready  input / output  1 each  write-data handshake.
REQ-011 wdata  input  DATA_W  write beat.
REQ-012 rdata_valid / rdata_ready  output / input  1 each  read-data handshake.
REQ-013 rdata  output  DATA_W  read beat; rdata_last  output  1  final beat of burst.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 CEN, WEN  output  1 each  SRAM chip/write enable, active-low.
REQ-016 A  output  ADDR_W  SRAM address; D  output  DATA_W  SRAM write data.
REQ-017 Q  input  DATA_W  SRAM read data, valid in the cycle after a read is issued and held until the next read.

Function
REQ-018 States IDLE, WRITE, READ, DRAIN; cmd_ready = 1 only in IDLE.
REQ-019 IDLE: cmd handshake latches cur_addr = cmd_addr and beats_left = cmd_len; next state WRITE if cmd_wr, else READ.
REQ-020 WRITE: wdata_ready = 1; each wdata handshake drives CEN = 0, WEN = 0, A = cur_addr, D = wdata combinationally in that cycle; cur_addr increments; one beat per cycle sustained.
REQ-021 WRITE: in cycles without a wdata handshake, CEN = 1.
REQ-022 WRITE: the handshake with beats_left = 0 completes the burst; next state IDLE.
REQ-023 READ: a 2-entry output FIFO holds read beats; a 1-bit inflight flag marks a read issued in the previous cycle.
REQ-024 READ: issue a read (CEN = 0, WEN = 1, A = cur_addr) when fifo_count + inflight < 2 minus any pop this cycle; otherwise CEN = 1.
REQ-025 Q is pushed into the FIFO in the cycle after issue, tagged last if it was the beat-0 read.
REQ-026 READ: after the read with beats_left = 0 is issued, next state DRAIN.
REQ-027 DRAIN: no SRAM access; go to IDLE when the FIFO is empty and inflight = 0.
REQ-028 rdata_valid = FIFO non-empty; rdata/rdata_last = FIFO head; pop on rdata_valid & rdata_ready.
REQ-029 With rdata_ready held high, sustained read throughput is one beat per cycle; first rdata_valid two cycles after first read issue.
REQ-030 cur_addr increments modulo 2^ADDR_W (2047 -> 0); bursts wrap silently.
REQ-031 Idle SRAM port values: CEN = 1, WEN = 1, A = 0, D = 0.
REQ-032 No FIFO overflow and no read beat lost under any rdata_ready pattern.

Reset
REQ-033 reset asserted: next state IDLE, FIFO emptied, inflight = 0, beats_left = 0, cur_addr = 0.
REQ-034 In a reset cycle, CEN = 1, WEN = 1, cmd_ready = 0, wdata_ready = 0, rdata_valid = 0; reset mid-burst abandons the burst with no further SRAM access.
REQ-035 After reset deasserts: cmd_ready = 1, busy = 0, rdata_valid = 0, rdata_last = 0.

Verification
REQ-036 Write burst: addr 0x010, len 3, wdata 0xA0..0xA3 back-to-back -> four consecutive cycles CEN = 0, WEN = 0, A 0x010..0x013, D 0xA0..0xA3; then IDLE.
REQ-037 Read-back: read addr 0x010, len 3, rdata_ready = 1 -> rdata 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles; rdata_last only on 0xA3.
REQ-038 Wrap: write addr 0x7FE, len 2 -> A = 0x7FE, 0x7FF, 0x000.
REQ-039 Backpressure: 8-beat read with rdata_ready low for 5 cycles mid-burst -> at most 2 beats buffered, CEN = 1 while stalled, all 8 beats delivered in order.
REQ-040 Write gaps: wdata_valid toggling 1,0,1,0 -> CEN = 0 only in valid cycles; addresses still contiguous.
REQ-041 Reset mid-read (after 2 of 6 beats) -> next cycle rdata_valid = 0, CEN = 1; after release cmd_ready = 1 and a new 1-beat read returns correct data.
